// File: rtl/bus_grant_arbiter.sv
// bus_grant_arbiter: 8-way round-robin bus arbiter with active-low one-hot
// grants, a bounded hold time per master and an idle guard gap between
// successive masters so two bus drivers can never overlap.

module bus_grant_arbiter #(
    parameter int MAX_HOLD  = 16,
    parameter int GUARD_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [7:0] gnt_n,
    output logic [2:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] hold_cnt;
    logic [3:0] guard_cnt;

    logic [2:0] sel;
    logic       found;
    logic [2:0] scan_idx;
    logic       vol_release;
    logic       hold_expired;

    // Pick the first requester at or after the round-robin pointer.
    always_comb begin
        sel      = 3'd0;
        found    = 1'b0;
        scan_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            scan_idx = ptr + 3'(i);
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end
    end

    // Exit conditions for the current master; voluntary release beats revoke.
    always_comb begin
        vol_release  = ~req[gnt_idx] | rel;
        hold_expired = (hold_cnt == 8'(MAX_HOLD));
    end

    // Arbitration state machine; every output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hold_cnt  <= 8'd0;
            guard_cnt <= 4'd0;
            gnt_n     <= 8'hFF;
            gnt_idx   <= 3'd0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    gnt_n <= 8'hFF;
                    busy  <= 1'b0;
                    if (en && found) begin
                        state    <= GRANT;
                        gnt_n    <= ~(8'd1 << sel);
                        gnt_idx  <= sel;
                        busy     <= 1'b1;
                        hold_cnt <= 8'd1;
                        ptr      <= sel + 3'd1;
                    end
                end
                GRANT: begin
                    if (vol_release || hold_expired) begin
                        state     <= GUARD;
                        gnt_n     <= 8'hFF;
                        guard_cnt <= 4'd1;
                        timeout   <= ~vol_release;
                    end else if (!hold_expired) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                GUARD: begin
                    gnt_n <= 8'hFF;
                    if (guard_cnt == 4'(GUARD_CYC)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_n <= 8'hFF;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// tb_bus_grant_arbiter: directed-vector bench for bus_grant_arbiter with
// hand-computed expected grant patterns.

module tb_bus_grant_arbiter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt_n;
    logic [2:0] gnt_idx;
    logic       busy;
    logic       timeout;

    int compared   = 0;
    int mismatched = 0;

    bus_grant_arbiter #(
        .MAX_HOLD (16),
        .GUARD_CYC(1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .req    (req),
        .rel    (rel),
        .gnt_n  (gnt_n),
        .gnt_idx(gnt_idx),
        .busy   (busy),
        .timeout(timeout)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // At most one grant line may ever be low.
    always @(negedge clk) begin
        if (!rst) begin
            assert ($countones(~gnt_n) <= 1)
            else $error("[TB] FAIL onehot gnt_n=%h", gnt_n);
        end
    end

    // Hard stop so the bench never hangs.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [7:0] r, input logic rl);
        en  = e;
        req = r;
        rel = rl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        tick();

        // Reset state.
        checkOutput("rst_gnt_n", gnt_n, 8'hFF);
        checkOutput("rst_idx", {5'd0, gnt_idx}, 8'd0);
        checkOutput("rst_busy", {7'd0, busy}, 8'd0);
        checkOutput("rst_timeout", {7'd0, timeout}, 8'd0);
        rst = 1'b0;

        // Single request, drop it, guard then idle.
        applyStimulus(1'b1, 8'h01, 1'b0);
        tick();
        checkOutput("t1_gnt_n", gnt_n, 8'hFE);
        checkOutput("t1_idx", {5'd0, gnt_idx}, 8'd0);
        checkOutput("t1_busy", {7'd0, busy}, 8'd1);
        applyStimulus(1'b1, 8'h00, 1'b0);
        tick();
        checkOutput("t1_drop_gnt_n", gnt_n, 8'hFF);
        checkOutput("t1_guard_busy", {7'd0, busy}, 8'd1);
        tick();
        checkOutput("t1_idle_busy", {7'd0, busy}, 8'd0);
        checkOutput("t1_idle_idx", {5'd0, gnt_idx}, 8'd0);

        // All requesting, release every third cycle: 0..7 then wrap to 0.
        doReset();
        applyStimulus(1'b1, 8'hFF, 1'b0);
        for (int k = 0; k < 9; k++) begin
            logic [7:0] exp_n;
            exp_n = ~(8'd1 << (k % 8));
            tick();
            checkOutput($sformatf("rr%0d_c1", k), gnt_n, exp_n);
            checkOutput($sformatf("rr%0d_idx", k), {5'd0, gnt_idx}, 8'(k % 8));
            tick();
            checkOutput($sformatf("rr%0d_c2", k), gnt_n, exp_n);
            tick();
            checkOutput($sformatf("rr%0d_c3", k), gnt_n, exp_n);
            rel = 1'b1;
            tick();
            rel = 1'b0;
            checkOutput($sformatf("rr%0d_gap1", k), gnt_n, 8'hFF);
            tick();
            checkOutput($sformatf("rr%0d_gap2", k), gnt_n, 8'hFF);
            checkOutput($sformatf("rr%0d_gap2_busy", k), {7'd0, busy}, 8'd0);
        end

        // Held request without release: forced revoke after 16 cycles.
        doReset();
        applyStimulus(1'b1, 8'h10, 1'b0);
        tick();
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) tick();
            checkOutput($sformatf("hold_c%0d", c), gnt_n, 8'hEF);
            checkOutput($sformatf("hold_to_c%0d", c), {7'd0, timeout}, 8'd0);
        end
        tick();
        checkOutput("revoke_gnt_n", gnt_n, 8'hFF);
        checkOutput("revoke_timeout", {7'd0, timeout}, 8'd1);
        tick();
        checkOutput("revoke_idle_timeout", {7'd0, timeout}, 8'd0);
        checkOutput("revoke_idle_gnt_n", gnt_n, 8'hFF);
        tick();
        checkOutput("regrant_gnt_n", gnt_n, 8'hEF);
        checkOutput("regrant_idx", {5'd0, gnt_idx}, 8'd4);

        // Asynchronous reset in the middle of a grant to 2.
        doReset();
        applyStimulus(1'b1, 8'h04, 1'b0);
        tick();
        checkOutput("arst_pre_gnt_n", gnt_n, 8'hFB);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_gnt_n", gnt_n, 8'hFF);
        checkOutput("arst_busy", {7'd0, busy}, 8'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 8'h05, 1'b0);
        tick();
        checkOutput("arst_ptr0_gnt_n", gnt_n, 8'hFE);
        checkOutput("arst_ptr0_idx", {5'd0, gnt_idx}, 8'd0);

        // Enable low blocks new grants.
        doReset();
        applyStimulus(1'b0, 8'h80, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            checkOutput($sformatf("en0_c%0d", c), gnt_n, 8'hFF);
        end
        en = 1'b1;
        tick();
        checkOutput("en1_gnt_n", gnt_n, 8'h7F);
        checkOutput("en1_idx", {5'd0, gnt_idx}, 8'd7);

        // Release coinciding with hold limit: drop without timeout.
        doReset();
        applyStimulus(1'b1, 8'h10, 1'b0);
        tick();
        for (int c = 2; c <= 16; c++) tick();
        checkOutput("relmax_c16", gnt_n, 8'hEF);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        checkOutput("relmax_gnt_n", gnt_n, 8'hFF);
        checkOutput("relmax_timeout", {7'd0, timeout}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
